// File: rtl/injection_scheduler_pkg.sv
// rtl/injection_scheduler_pkg.sv - package efi_sched_pkg: sizes, channel state type, load saturation
// Tooth count comes from CFG_NUM_TEETH (60 when not supplied by the build).
`ifndef CFG_NUM_TEETH
`define CFG_NUM_TEETH 60
`endif

package efi_sched_pkg;
    localparam int NUM_CYL   = 4;
    localparam int NUM_TEETH = `CFG_NUM_TEETH;
    localparam int TOOTH_W   = $clog2(NUM_TEETH);
    localparam int CYL_W     = $clog2(NUM_CYL);
    localparam int PW_W      = 20;
    localparam int DEAD_CYC  = 62500;

    localparam logic [PW_W-1:0]  PW_MAX    = {PW_W{1'b1}};
    localparam logic [PW_W-1:0]  DEAD_PW   = DEAD_CYC[PW_W-1:0];
    localparam logic [TOOTH_W:0] TEETH_LIM = NUM_TEETH[TOOTH_W:0];

    typedef enum logic {CH_IDLE, CH_FIRE} chan_state_t;

    // One extra bit catches the carry so long pulses clamp instead of wrapping short.
    function automatic logic [PW_W-1:0] sat_load(input logic [PW_W-1:0] pw,
                                                 input logic [PW_W-1:0] extra);
        logic [PW_W:0] sum;
        sum = {1'b0, pw} + {1'b0, extra};
        return sum[PW_W] ? PW_MAX : sum[PW_W-1:0];
    endfunction
endpackage

// File: rtl/injection_scheduler_if.sv
// rtl/injection_scheduler_if.sv - configuration write channel between host and injection scheduler
interface injection_scheduler_if;
    import efi_sched_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CYL_W-1:0]   cfg_cyl;
    logic [TOOTH_W-1:0] cfg_tooth;
    logic [PW_W-1:0]    cfg_pw;
    logic               cfg_err;

    modport master (output cfg_valid, cfg_cyl, cfg_tooth, cfg_pw,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_cyl, cfg_tooth, cfg_pw,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/injection_scheduler_channel.sv
// rtl/injection_scheduler_channel.sv - inj_channel: one injector's pulse FSM, timer and overrun flag
module inj_channel
    import efi_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_on,
    input  logic            i_trig,
    input  logic [PW_W-1:0] i_load,
    input  logic            i_ovr_clr,
    output logic            o_inj,
    output logic            o_ovr
);
    chan_state_t     r_state, w_state_nxt;
    logic [PW_W-1:0] r_timer, w_timer_nxt;
    logic            r_inj, w_inj_nxt;
    logic            r_ovr, w_ovr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CH_IDLE;
            r_timer <= '0;
            r_inj   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_inj   <= w_inj_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_inj_nxt   = r_inj;
        w_ovr_nxt   = r_ovr;

        if (i_trig && r_state == CH_FIRE)
            w_ovr_nxt = 1'b1;
        else if (i_ovr_clr)
            w_ovr_nxt = 1'b0;

        if (!i_on) begin
            w_state_nxt = CH_IDLE;
            w_timer_nxt = '0;
            w_inj_nxt   = 1'b0;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (i_trig) begin
                        w_state_nxt = CH_FIRE;
                        w_timer_nxt = i_load;
                        w_inj_nxt   = 1'b1;
                    end
                end
                CH_FIRE: begin
                    // Timer value 1 marks the last high cycle; this edge drops the injector.
                    if (r_timer == PW_W'(1)) begin
                        w_state_nxt = CH_IDLE;
                        w_timer_nxt = '0;
                        w_inj_nxt   = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end
                default: w_state_nxt = CH_IDLE;
            endcase
        end
    end

    assign o_inj = r_inj;
    assign o_ovr = r_ovr;
endmodule

// File: rtl/injection_scheduler.sv
// rtl/injection_scheduler.sv - per-cylinder injector pulse scheduler with shadowed configuration
// INJ_DEAD_TIME_EN adds the injector opening dead time to every pulse.
module injection_scheduler
    import efi_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_on,
    input  logic [TOOTH_W-1:0]  i_crank_counter,
    input  logic                i_crank_changed,
    input  logic                i_crank_tick,
    input  logic                i_ovr_clr,
    injection_scheduler_if.slave cfg,
    output logic [NUM_CYL-1:0]  o_inj,
    output logic [NUM_CYL-1:0]  o_ovr
);
    logic [TOOTH_W-1:0] r_sh_tooth  [NUM_CYL];
    logic [PW_W-1:0]    r_sh_pw     [NUM_CYL];
    logic [TOOTH_W-1:0] r_act_tooth [NUM_CYL];
    logic [PW_W-1:0]    r_act_pw    [NUM_CYL];
    logic               r_pend;
    logic               r_cfg_err;

    logic w_ready, w_accept, w_bad, w_wr, w_copy;

    assign w_ready  = !(r_pend && i_on);
    assign w_accept = cfg.cfg_valid && w_ready;
    assign w_bad    = {1'b0, cfg.cfg_tooth} >= TEETH_LIM;
    assign w_wr     = w_accept && !w_bad;
    // Active config only moves at an engine-cycle boundary, or freely while the scheduler is off.
    assign w_copy   = (i_crank_tick && i_crank_changed) || !i_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CYL; i++) begin
                r_sh_tooth[i]  <= '0;
                r_sh_pw[i]     <= '0;
                r_act_tooth[i] <= '0;
                r_act_pw[i]    <= '0;
            end
        end else begin
            r_cfg_err <= w_accept && w_bad;
            if (w_wr) begin
                r_sh_tooth[cfg.cfg_cyl] <= cfg.cfg_tooth;
                r_sh_pw[cfg.cfg_cyl]    <= cfg.cfg_pw;
                r_pend                  <= 1'b1;
            end else if (w_copy) begin
                r_pend <= 1'b0;
            end
            if (w_copy) begin
                for (int i = 0; i < NUM_CYL; i++) begin
                    r_act_tooth[i] <= r_sh_tooth[i];
                    r_act_pw[i]    <= r_sh_pw[i];
                end
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_err   = r_cfg_err;

    for (genvar g = 0; g < NUM_CYL; g++) begin : g_ch
        logic [PW_W-1:0] w_load;
        logic            w_trig;

`ifdef INJ_DEAD_TIME_EN
        assign w_load = sat_load(r_act_pw[g], DEAD_PW);
`else
        assign w_load = sat_load(r_act_pw[g], '0);
`endif
        assign w_trig = i_on && i_crank_changed && (i_crank_counter == r_act_tooth[g])
                        && (r_act_pw[g] != '0);

        inj_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_on      (i_on),
            .i_trig    (w_trig),
            .i_load    (w_load),
            .i_ovr_clr (i_ovr_clr),
            .o_inj     (o_inj[g]),
            .o_ovr     (o_ovr[g])
        );
    end
endmodule
